fpu_operand_unpacker: RTL and testbench

- Pipelined front end of the FPU datapath.
- Takes a raw IEEE-754 binary32 operand and produces the per-operand status flags consumed by the FCLASS classifier: sign, isSubnormal, isZero, isInf, isNaN, isSignaling.
- Also produces a normalized unbiased exponent and a mantissa with the hidden bit made explicit, for the arithmetic units.
- Two-stage valid/ready pipeline sitting between the FP register-file read and the FP execute units.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_lzc23.sv | 18 +
 rtl/fpu_operand_unpacker.sv | 117 +++++++++++
 tb/tb_fpu_operand_unpacker.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 field constants and the unpacked-operand bundle used across the FPU datapath.
// Pure declarations: no latency, no flow control.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;
  localparam int UEXP_W = 10;
  localparam int LZ_W   = 5;
  localparam int QNAN_BIT = 22;

  localparam logic [EXP_W-1:0]         EXP_ALL_ONES = 8'hFF;
  localparam logic signed [UEXP_W-1:0] UEXP_INF_NAN = 10'sd128;

  // Raw fields plus decoded class, as held between the two unpack stages.
  typedef struct packed {
    logic             sign;
    logic             is_subnormal;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
    logic             is_signaling;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
    logic [LZ_W-1:0]  lz;
  } raw_op_t;

  typedef struct packed {
    logic                     sign;
    logic                     is_subnormal;
    logic                     is_zero;
    logic                     is_inf;
    logic                     is_nan;
    logic                     is_signaling;
    logic signed [UEXP_W-1:0] exp;
    logic [MAN_W:0]           mant;
  } unpacked_op_t;

endpackage

// File: rtl/fpu_lzc23.sv
// Combinational leading-zero count over a 23-bit fraction; returns 23 for an all-zero input.
// Zero latency, no flow control.
module fpu_lzc23
  import fpu_pkg::*;
(
  input  logic [MAN_W-1:0] val_i,
  output logic [LZ_W-1:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last to write the count.
  always_comb begin
    cnt_o = LZ_W'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (val_i[i]) cnt_o = LZ_W'(MAN_W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_operand_unpacker.sv
// Two-stage unpacker: decode class + LZC, then normalize exponent/mantissa. Latency 2, 1/cycle.
// Stage 2 holds while valid_o & !ready_i; stage 1 accepts only when empty or draining.
module fpu_operand_unpacker
  import fpu_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [31:0]              operand_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     sign_o,
  output logic                     isSubnormal_o,
  output logic                     isZero_o,
  output logic                     isInf_o,
  output logic                     isNaN_o,
  output logic                     isSignaling_o,
  output logic signed [UEXP_W-1:0] exp_o,
  output logic [MAN_W:0]           mant_o
);

  logic         s1_valid_q, s2_valid_q;
  logic         s1_adv, s2_adv;
  raw_op_t      s1_d, s1_q;
  unpacked_op_t out_d, out_q;
  logic [EXP_W-1:0] e_in;
  logic [MAN_W-1:0] f_in;
  logic [LZ_W-1:0]  lz_in;
  logic e_zero, e_ones, f_zero;

  assign s2_adv  = !s2_valid_q || ready_i;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign ready_o = s1_adv;

  assign e_in   = operand_i[30:23];
  assign f_in   = operand_i[22:0];
  assign e_zero = (e_in == '0);
  assign e_ones = (e_in == EXP_ALL_ONES);
  assign f_zero = (f_in == '0);

  fpu_lzc23 u_lzc (
    .val_i (f_in),
    .cnt_o (lz_in)
  );

  always_comb begin
    s1_d              = '0;
    s1_d.sign         = operand_i[31];
    s1_d.is_subnormal = e_zero && !f_zero;
    s1_d.is_zero      = e_zero && f_zero;
    s1_d.is_inf       = e_ones && f_zero;
    s1_d.is_nan       = e_ones && !f_zero;
    s1_d.is_signaling = e_ones && !f_zero && !f_in[QNAN_BIT];
    s1_d.exp          = e_in;
    s1_d.frac         = f_in;
    s1_d.lz           = lz_in;
  end

  always_comb begin
    out_d              = '0;
    out_d.sign         = s1_q.sign;
    out_d.is_subnormal = s1_q.is_subnormal;
    out_d.is_zero      = s1_q.is_zero;
    out_d.is_inf       = s1_q.is_inf;
    out_d.is_nan       = s1_q.is_nan;
    out_d.is_signaling = s1_q.is_signaling;
    if (s1_q.is_zero) begin
      out_d.exp  = '0;
      out_d.mant = '0;
    end else if (s1_q.is_subnormal) begin
      // Shift the leading one into the hidden-bit position.
      out_d.mant = {1'b0, s1_q.frac} << (s1_q.lz + LZ_W'(1));
      out_d.exp  = UEXP_W'(-BIAS) - UEXP_W'(s1_q.lz);
    end else if (s1_q.is_inf || s1_q.is_nan) begin
      out_d.exp  = UEXP_INF_NAN;
      out_d.mant = {1'b0, s1_q.frac};
    end else begin
      out_d.exp  = UEXP_W'(s1_q.exp) - UEXP_W'(BIAS);
      out_d.mant = {1'b1, s1_q.frac};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      if (flush_i) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (s1_adv) s1_valid_q <= valid_i;
        if (s2_adv) s2_valid_q <= s1_valid_q;
      end
      if (s2_adv && s1_valid_q) out_q <= out_d;
    end
  end

  // Stage-1 payload needs no reset; its valid bit qualifies it.
  always_ff @(posedge clk_i) begin
    if (s1_adv && valid_i) s1_q <= s1_d;
  end

  assign valid_o       = s2_valid_q;
  assign sign_o        = out_q.sign;
  assign isSubnormal_o = out_q.is_subnormal;
  assign isZero_o      = out_q.is_zero;
  assign isInf_o       = out_q.is_inf;
  assign isNaN_o       = out_q.is_nan;
  assign isSignaling_o = out_q.is_signaling;
  assign exp_o         = out_q.exp;
  assign mant_o        = out_q.mant;

endmodule

// File: tb/tb_fpu_operand_unpacker.sv
// Directed bench for fpu_operand_unpacker: classification, normalization, stall, flush and reset.
module tb_fpu_operand_unpacker;

  logic        clk_i = 1'b0;
  logic        reset_i, valid_i, ready_i, flush_i;
  logic [31:0] operand_i;
  logic        ready_o, valid_o, sign_o;
  logic        isSubnormal_o, isZero_o, isInf_o, isNaN_o, isSignaling_o;
  logic signed [9:0] exp_o;
  logic [23:0] mant_o;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_operand_unpacker dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .operand_i     (operand_i),
    .flush_i       (flush_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .sign_o        (sign_o),
    .isSubnormal_o (isSubnormal_o),
    .isZero_o      (isZero_o),
    .isInf_o       (isInf_o),
    .isNaN_o       (isNaN_o),
    .isSignaling_o (isSignaling_o),
    .exp_o         (exp_o),
    .mant_o        (mant_o)
  );

  always #5 clk_i = ~clk_i;

  // {valid, sign, sub, zero, inf, nan, snan, exp[9:0], mant[23:0]}
  logic [40:0] obs;
  assign obs = {valid_o, sign_o, isSubnormal_o, isZero_o, isInf_o, isNaN_o,
                isSignaling_o, exp_o, mant_o};

  function automatic logic [40:0] bnd(logic [5:0] fl, logic [9:0] e, logic [23:0] m);
    return {1'b1, fl, e, m};
  endfunction

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic single(string tag, logic [31:0] op, logic [40:0] e);
    valid_i = 1'b1; operand_i = op;
    step();
    valid_i = 1'b0; operand_i = '0;
    chk({tag, "_lat"}, 64'(valid_o), 64'd0);
    step();
    chk(tag, 64'(obs), 64'(e));
    step();
  endtask

  logic [31:0] s_ops [4];
  logic [40:0] s_exp [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, flush_seen;
    logic        prev_stall;
    logic [40:0] prev_obs;

    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0; operand_i = '0;
    @(negedge clk_i);
    step();
    reset_i = 1'b0;
    chk("reset_outputs", 64'(obs), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd1);

    // Single operands, no backpressure; flags = {sign,sub,zero,inf,nan,snan}.
    single("one",      32'h3F800000, bnd(6'b000000, 10'h000, 24'h800000));
    single("sub_min",  32'h00000001, bnd(6'b010000, 10'h36B, 24'h800000));
    single("sub_max",  32'h00400000, bnd(6'b010000, 10'h381, 24'h800000));
    single("snan",     32'h7F800001, bnd(6'b000011, 10'h080, 24'h000001));
    single("qnan",     32'h7FC00000, bnd(6'b000010, 10'h080, 24'h400000));
    single("neg_inf",  32'hFF800000, bnd(6'b100100, 10'h080, 24'h000000));
    single("neg_zero", 32'h80000000, bnd(6'b101000, 10'h000, 24'h000000));
    single("neg_pi",   32'hC0490FDB, bnd(6'b100000, 10'h001, 24'hC90FDB));

    // Back-to-back stream with a 3-cycle downstream stall.
    s_ops[0] = 32'h3F800000; s_exp[0] = bnd(6'b000000, 10'h000, 24'h800000);
    s_ops[1] = 32'h40000000; s_exp[1] = bnd(6'b000000, 10'h001, 24'h800000);
    s_ops[2] = 32'h00000001; s_exp[2] = bnd(6'b010000, 10'h36B, 24'h800000);
    s_ops[3] = 32'hBF800000; s_exp[3] = bnd(6'b100000, 10'h000, 24'h800000);
    sent = 0; got = 0; prev_stall = 1'b0; prev_obs = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      ready_i = !(cyc >= 2 && cyc < 5);
      valid_i = (sent < 4);
      if (sent < 4) operand_i = s_ops[sent];
      else          operand_i = '0;
      #1;
      if (prev_stall) chk("stall_hold", 64'(obs), 64'(prev_obs));
      if (cyc == 2) begin
        chk("first_valid_cycle", 64'(valid_o), 64'd1);
        chk("full_ready_low", 64'(ready_o), 64'd0);
      end
      if (valid_o && ready_i) begin
        chk($sformatf("stream_%0d", got), 64'(obs), 64'(s_exp[got]));
        got++;
      end
      if (valid_i && ready_o) sent++;
      prev_stall = valid_o && !ready_i;
      prev_obs   = obs;
      @(negedge clk_i);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    chk("stream_sent", 64'(sent), 64'd4);
    chk("stream_got", 64'(got), 64'd4);
    step();
    chk("stream_no_dup", 64'(valid_o), 64'd0);

    // Flush with one operand at the output (stalled) and one in stage 1.
    ready_i = 1'b0;
    valid_i = 1'b1; operand_i = 32'h40400000;
    step();
    operand_i = 32'h40800000;
    step();
    chk("flush_pre_valid", 64'(valid_o), 64'd1);
    flush_i = 1'b1; operand_i = 32'h41000000;
    step();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_ready", 64'(ready_o), 64'd1);
    flush_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (valid_o) flush_seen++;
      step();
    end
    chk("flush_nothing_out", 64'(flush_seen), 64'd0);

    // Reset mid-stream.
    valid_i = 1'b1; operand_i = 32'h3F800000;
    step();
    operand_i = 32'h40000000;
    step();
    chk("rst_pre_valid", 64'(valid_o), 64'd1);
    reset_i = 1'b1; valid_i = 1'b0;
    step();
    chk("rst_outputs", 64'(obs), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    reset_i = 1'b0;
    step();
    chk("rst_no_partial", 64'(valid_o), 64'd0);

    // Flush and reset together: same result as reset.
    valid_i = 1'b1; operand_i = 32'h3F800000;
    step();
    step();
    valid_i = 1'b0;
    reset_i = 1'b1; flush_i = 1'b1;
    step();
    reset_i = 1'b0; flush_i = 1'b0;
    chk("rst_flush_outputs", 64'(obs), 64'd0);
    chk("rst_flush_ready", 64'(ready_o), 64'd1);

    // Pipeline still usable afterwards.
    single("post_reset", 32'h00400000, bnd(6'b010000, 10'h381, 24'h800000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
